// File: rtl/proc_cache_ctrl.sv
// ---------------------------------------------------------------------------
// proc_cache_ctrl
//
// Purpose:
//    Direct-mapped, write-through, write-allocate byte cache placed behind a
//    free-running processor traffic source. The source never stalls. Each
//    request {RWB, Address, Data} therefore goes into a small request FIFO.
//    A three-state FSM (IDLE / LOOKUP / FILL) then serves the requests one
//    at a time. The backing store is an internal 64x8 memory, and a read
//    miss pays MEM_LATENCY cycles before the line is loaded. Hit, miss and
//    drop statistics are kept in saturating 16-bit counters.
//
// Parameters:
//    MEM_LATENCY  cycles a read miss spends in FILL (1..15)
//    FIFO_DEPTH   request FIFO entries (power of 2, 2..16)
//
// Ports:
//    clk          system clock, all logic on posedge
//    start        synchronous active-high reset
//    req_en       request strobe
//    RWB          1 = read, 0 = write
//    Address      byte address; tag = Address[5:3], index = Address[2:0]
//    Data         write data (ignored for reads)
//    rdata        last read result, held until the next read completes
//    rdata_valid  one-cycle pulse when rdata is updated
//    busy         FSM not IDLE or FIFO non-empty
//    hit_count    read and write hits, saturating
//    miss_count   read and write misses, saturating
//    drop_count   requests lost to a full FIFO, saturating
// ---------------------------------------------------------------------------
module proc_cache_ctrl #(
   parameter int MEM_LATENCY = 4,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        start,
   input  logic        req_en,
   input  logic        RWB,
   input  logic [5:0]  Address,
   input  logic [7:0]  Data,
   output logic [7:0]  rdata,
   output logic        rdata_valid,
   output logic        busy,
   output logic [15:0] hit_count,
   output logic [15:0] miss_count,
   output logic [15:0] drop_count
);

   // Pointer width and occupancy-counter width for the request FIFO.
   // The occupancy counter needs one extra bit so it can represent "full".
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;

   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);

   // FILL counts down from MEM_LATENCY-1 to 0, which gives exactly
   // MEM_LATENCY cycles spent in FILL.
   localparam logic [3:0]    LAT_LOAD = 4'(MEM_LATENCY - 1);

   typedef struct packed {
      logic       rwb;
      logic [5:0] addr;
      logic [7:0] data;
   } req_t;

   typedef enum logic [1:0] {
      IDLE,
      LOOKUP,
      FILL
   } state_t;

   // ------------------------------------------------------------------
   // Request FIFO storage
   // ------------------------------------------------------------------
   req_t          fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] fifo_cnt;
   logic          fifo_full;
   logic          fifo_empty;
   logic          push;
   logic          pop;

   // ------------------------------------------------------------------
   // FSM, request register, cache arrays and backing memory
   // ------------------------------------------------------------------
   state_t     state;
   req_t       req;
   logic [3:0] lat_cnt;
   logic [7:0] mem        [64];
   logic [7:0] valid;
   logic [2:0] tag_store  [8];
   logic [7:0] data_store [8];

   logic [2:0] req_index;
   logic [2:0] req_tag;
   logic       lookup_hit;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign fifo_full  = (fifo_cnt == FULL_CNT);
   assign fifo_empty = (fifo_cnt == '0);

   // Fullness is judged on the count before this edge, so a pop in the
   // same cycle never makes room for that cycle's push.
   assign push = req_en && !fifo_full;
   assign pop  = (state == IDLE) && !fifo_empty;

   assign busy = (state != IDLE) || !fifo_empty;

   assign req_index  = req.addr[2:0];
   assign req_tag    = req.addr[5:3];

   // valid is cleared at reset, so a not-yet-written tag_store entry is
   // masked off by the AND.
   assign lookup_hit = valid[req_index] && (tag_store[req_index] == req_tag);

   // ------------------------------------------------------------------
   // Request FIFO and drop accounting
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (start) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_cnt   <= '0;
         drop_count <= '0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= {RWB, Address, Data};
            wr_ptr           <= wr_ptr + PTR_ONE;
         end

         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end

         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
            2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
            default: fifo_cnt <= fifo_cnt;
         endcase

         if (req_en && fifo_full) begin
            drop_count <= sat_inc(drop_count);
         end
      end
   end

   // ------------------------------------------------------------------
   // Cache FSM with registered outputs
   //
   // Memory and cache line are updated together on writes, which keeps
   // the cache coherent with memory at all times (write-through).
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (start) begin
         state       <= IDLE;
         req         <= '0;
         lat_cnt     <= '0;
         valid       <= '0;
         rdata       <= '0;
         rdata_valid <= 1'b0;
         hit_count   <= '0;
         miss_count  <= '0;
         for (int i = 0; i < 64; i++) begin
            mem[i[5:0]] <= 8'h00;
         end
      end else begin
         rdata_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (pop) begin
                  req   <= fifo_mem[rd_ptr];
                  state <= LOOKUP;
               end
            end

            LOOKUP: begin
               if (!req.rwb) begin
                  // Write-allocate: the line is claimed whether or not it hit.
                  mem[req.addr]         <= req.data;
                  data_store[req_index] <= req.data;
                  tag_store[req_index]  <= req_tag;
                  valid[req_index]      <= 1'b1;
                  if (lookup_hit) begin
                     hit_count <= sat_inc(hit_count);
                  end else begin
                     miss_count <= sat_inc(miss_count);
                  end
                  state <= IDLE;
               end else if (lookup_hit) begin
                  hit_count   <= sat_inc(hit_count);
                  rdata       <= data_store[req_index];
                  rdata_valid <= 1'b1;
                  state       <= IDLE;
               end else begin
                  miss_count <= sat_inc(miss_count);
                  lat_cnt    <= LAT_LOAD;
                  state      <= FILL;
               end
            end

            FILL: begin
               if (lat_cnt == 4'd0) begin
                  data_store[req_index] <= mem[req.addr];
                  tag_store[req_index]  <= req_tag;
                  valid[req_index]      <= 1'b1;
                  rdata                 <= mem[req.addr];
                  rdata_valid           <= 1'b1;
                  state                 <= IDLE;
               end else begin
                  lat_cnt <= lat_cnt - 4'd1;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_proc_cache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_proc_cache_ctrl
//
// Purpose:
//    Self-checking bench for proc_cache_ctrl. A transaction-level reference
//    model is stepped once per clock edge. It holds a memory array, cache
//    line arrays and a request queue. A server is modelled as "free again
//    at edge N". Each read's result is scheduled for a computed future edge.
//    Outputs are sampled on the falling edge.
//
// Ports:
//    none (top-level testbench)
// ---------------------------------------------------------------------------
module tb_proc_cache_ctrl;

   localparam int LAT   = 4;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        start;
   logic        req_en;
   logic        RWB;
   logic [5:0]  Address;
   logic [7:0]  Data;
   logic [7:0]  rdata;
   logic        rdata_valid;
   logic        busy;
   logic [15:0] hit_count;
   logic [15:0] miss_count;
   logic [15:0] drop_count;

   int n_checks = 0;
   int n_pass   = 0;

   proc_cache_ctrl #(
      .MEM_LATENCY (LAT),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk         (clk),
      .start       (start),
      .req_en      (req_en),
      .RWB         (RWB),
      .Address     (Address),
      .Data        (Data),
      .rdata       (rdata),
      .rdata_valid (rdata_valid),
      .busy        (busy),
      .hit_count   (hit_count),
      .miss_count  (miss_count),
      .drop_count  (drop_count)
   );

   always #5 clk = ~clk;

   // ------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------
   typedef struct packed {
      logic       rwb;
      logic [5:0] addr;
      logic [7:0] data;
   } txn_t;

   txn_t       m_q[$];
   logic [7:0] m_mem  [64];
   logic       m_valid[8];
   logic [2:0] m_tag  [8];
   logic [7:0] m_line [8];
   int         m_hit       = 0;
   int         m_miss      = 0;
   int         m_drop      = 0;
   int         m_edge      = 0;
   int         m_next_pop  = 0;
   int         m_pend_edge = -1;
   logic [7:0] m_pend_data = 8'h00;
   logic [7:0] m_rdata     = 8'h00;
   logic       m_rvalid    = 1'b0;

   function automatic int sat(input int v);
      return (v >= 65535) ? 65535 : v + 1;
   endfunction

   function automatic bit m_busy();
      return (m_edge < m_next_pop - 1) || (m_q.size() > 0);
   endfunction

   task automatic model_edge(input logic rst, input logic en, input logic rwb,
                             input logic [5:0] addr, input logic [7:0] data);
      int   pre;
      int   idx;
      txn_t t;
      logic is_hit;
      m_edge++;
      if (rst) begin
         m_q.delete();
         for (int i = 0; i < 64; i++) m_mem[i] = 8'h00;
         for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
         m_hit       = 0;
         m_miss      = 0;
         m_drop      = 0;
         m_next_pop  = m_edge + 1;
         m_pend_edge = -1;
         m_rdata     = 8'h00;
         m_rvalid    = 1'b0;
      end else begin
         m_rvalid = 1'b0;
         if (m_pend_edge == m_edge) begin
            m_rvalid    = 1'b1;
            m_rdata     = m_pend_data;
            m_pend_edge = -1;
         end
         pre = m_q.size();
         if (m_edge >= m_next_pop && pre > 0) begin
            t      = m_q.pop_front();
            idx    = int'(t.addr[2:0]);
            is_hit = m_valid[idx] && (m_tag[idx] == t.addr[5:3]);
            if (!t.rwb) begin
               m_mem[t.addr] = t.data;
               m_line[idx]   = t.data;
               m_tag[idx]    = t.addr[5:3];
               m_valid[idx]  = 1'b1;
               if (is_hit) m_hit = sat(m_hit);
               else        m_miss = sat(m_miss);
               m_next_pop = m_edge + 2;
            end else if (is_hit) begin
               m_hit       = sat(m_hit);
               m_pend_edge = m_edge + 1;
               m_pend_data = m_line[idx];
               m_next_pop  = m_edge + 2;
            end else begin
               m_miss       = sat(m_miss);
               m_line[idx]  = m_mem[t.addr];
               m_tag[idx]   = t.addr[5:3];
               m_valid[idx] = 1'b1;
               m_pend_edge  = m_edge + 1 + LAT;
               m_pend_data  = m_mem[t.addr];
               m_next_pop   = m_edge + 2 + LAT;
            end
         end
         if (en) begin
            if (pre < DEPTH) m_q.push_back({rwb, addr, data});
            else             m_drop = sat(m_drop);
         end
      end
   endtask

   // Drive one cycle of inputs, let the edge happen, step the model and
   // return on the following falling edge for sampling.
   task automatic tick(input logic rst, input logic en, input logic rwb,
                       input logic [5:0] addr, input logic [7:0] data);
      start   = rst;
      req_en  = en;
      RWB     = rwb;
      Address = addr;
      Data    = data;
      @(posedge clk);
      model_edge(rst, en, rwb, addr, data);
      @(negedge clk);
   endtask

   // ------------------------------------------------------------------
   // Tests
   // ------------------------------------------------------------------
   task automatic test_reset();
      tick(1'b1, 1'b1, 1'b1, 6'h21, 8'h00);
      tick(1'b1, 1'b1, 1'b0, 6'h0B, 8'hA5);
      n_checks++; if (hit_count !== 16'd0) $display("[TB] FAIL rst_hit: got %0d expected 0", hit_count); else n_pass++;
      n_checks++; if (miss_count !== 16'd0) $display("[TB] FAIL rst_miss: got %0d expected 0", miss_count); else n_pass++;
      n_checks++; if (drop_count !== 16'd0) $display("[TB] FAIL rst_drop: got %0d expected 0", drop_count); else n_pass++;
      n_checks++; if (rdata !== 8'h00) $display("[TB] FAIL rst_rdata: got %0h expected 00", rdata); else n_pass++;
      n_checks++; if (rdata_valid !== 1'b0) $display("[TB] FAIL rst_rvalid: got %0b expected 0", rdata_valid); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("[TB] FAIL rst_busy: got %0b expected 0", busy); else n_pass++;
      tick(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
      n_checks++; if (busy !== 1'b0) $display("[TB] FAIL rst_nopush: busy got %0b expected 0", busy); else n_pass++;
   endtask

   task automatic test_cold_read();
      int push_edge;
      int seen;
      tick(1'b1, 1'b0, 1'b0, 6'h00, 8'h00);
      for (int pass = 0; pass < 2; pass++) begin
         tick(1'b0, 1'b1, 1'b1, 6'h21, 8'h00);
         push_edge = m_edge;
         seen      = -1;
         for (int c = 0; c < 16; c++) begin
            tick(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
            n_checks++;
            if (rdata_valid !== m_rvalid) $display("[TB] FAIL cold_rvalid: got %0b expected %0b", rdata_valid, m_rvalid);
            else n_pass++;
            if (rdata_valid === 1'b1 && seen < 0) seen = m_edge - push_edge;
         end
         n_checks++;
         if (seen !== ((pass == 0) ? 2 + LAT : 2)) $display("[TB] FAIL cold_latency: got %0d expected %0d", seen, (pass == 0) ? 2 + LAT : 2);
         else n_pass++;
         n_checks++; if (rdata !== 8'h00) $display("[TB] FAIL cold_rdata: got %0h expected 00", rdata); else n_pass++;
      end
      n_checks++; if (miss_count !== 16'd1) $display("[TB] FAIL cold_miss: got %0d expected 1", miss_count); else n_pass++;
      n_checks++; if (hit_count !== 16'd1) $display("[TB] FAIL cold_hit: got %0d expected 1", hit_count); else n_pass++;
   endtask

   task automatic test_write_allocate();
      logic       t_rwb [4];
      logic [5:0] t_addr[4];
      logic [7:0] t_data[4];
      logic [7:0] exp_rd[3];
      int         n_rd;
      t_rwb  = '{1'b0, 1'b1, 1'b1, 1'b1};
      t_addr = '{6'h0B, 6'h0B, 6'h03, 6'h0B};
      t_data = '{8'hA5, 8'h00, 8'h00, 8'h00};
      exp_rd = '{8'hA5, 8'h00, 8'hA5};
      n_rd   = 0;
      tick(1'b1, 1'b0, 1'b0, 6'h00, 8'h00);
      for (int r = 0; r < 4; r++) begin
         tick(1'b0, 1'b1, t_rwb[r], t_addr[r], t_data[r]);
         for (int c = 0; c < 20 && m_busy(); c++) begin
            tick(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
            n_checks++;
            if (rdata_valid !== m_rvalid) $display("[TB] FAIL wa_rvalid: got %0b expected %0b", rdata_valid, m_rvalid);
            else n_pass++;
            if (m_rvalid && n_rd < 3) begin
               n_checks++;
               if (rdata !== exp_rd[n_rd]) $display("[TB] FAIL wa_rdata%0d: got %0h expected %0h", n_rd, rdata, exp_rd[n_rd]);
               else n_pass++;
               n_rd++;
            end
         end
      end
      n_checks++; if (n_rd !== 3) $display("[TB] FAIL wa_nreads: got %0d expected 3", n_rd); else n_pass++;
      n_checks++; if (hit_count !== 16'd1) $display("[TB] FAIL wa_hit: got %0d expected 1", hit_count); else n_pass++;
      n_checks++; if (miss_count !== 16'd3) $display("[TB] FAIL wa_miss: got %0d expected 3", miss_count); else n_pass++;
   endtask

   task automatic test_overflow();
      logic [5:0] addrs[20];
      tick(1'b1, 1'b0, 1'b0, 6'h00, 8'h00);
      for (int c = 0; c < 20; c++) begin
         addrs[c] = 6'($urandom_range(0, 63));
         tick(1'b0, 1'b1, 1'b0, addrs[c], 8'($urandom_range(1, 255)));
         n_checks++;
         if (drop_count !== 16'(m_drop)) $display("[TB] FAIL ovf_drop: got %0d expected %0d", drop_count, m_drop);
         else n_pass++;
      end
      for (int c = 0; c < 100 && m_busy(); c++) tick(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
      n_checks++; if (busy !== 1'b0) $display("[TB] FAIL ovf_drain: busy got %0b expected 0", busy); else n_pass++;
      n_checks++;
      if (32'(hit_count) + 32'(miss_count) + 32'(drop_count) !== 32'd20)
         $display("[TB] FAIL ovf_total: got %0d expected 20", 32'(hit_count) + 32'(miss_count) + 32'(drop_count));
      else n_pass++;
      n_checks++; if (drop_count === 16'd0) $display("[TB] FAIL ovf_nodrop: got %0d expected nonzero", drop_count); else n_pass++;
      // Read every written address back; corrupted FIFO entries would show
      // up as memory contents that differ from the model.
      for (int r = 0; r < 20; r++) begin
         tick(1'b0, 1'b1, 1'b1, addrs[r], 8'h00);
         for (int c = 0; c < 20 && m_busy(); c++) begin
            tick(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
            n_checks++;
            if (rdata_valid !== m_rvalid) $display("[TB] FAIL ovf_rvalid: got %0b expected %0b", rdata_valid, m_rvalid);
            else n_pass++;
            if (m_rvalid) begin
               n_checks++;
               if (rdata !== m_rdata) $display("[TB] FAIL ovf_rdata: got %0h expected %0h", rdata, m_rdata);
               else n_pass++;
            end
         end
      end
   endtask

   task automatic test_mid_fill_reset();
      tick(1'b1, 1'b0, 1'b0, 6'h00, 8'h00);
      tick(1'b0, 1'b1, 1'b0, 6'h15, 8'h77);
      for (int c = 0; c < 20 && m_busy(); c++) tick(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
      // Read miss on index 5 with a different tag, then reset during the
      // second FILL cycle.
      tick(1'b0, 1'b1, 1'b1, 6'h2D, 8'h00);
      tick(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
      tick(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
      tick(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
      tick(1'b1, 1'b0, 1'b0, 6'h00, 8'h00);
      n_checks++; if (hit_count !== 16'd0) $display("[TB] FAIL mfr_hit: got %0d expected 0", hit_count); else n_pass++;
      n_checks++; if (miss_count !== 16'd0) $display("[TB] FAIL mfr_miss: got %0d expected 0", miss_count); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("[TB] FAIL mfr_busy: got %0b expected 0", busy); else n_pass++;
      for (int c = 0; c < 2 * LAT; c++) begin
         tick(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
         n_checks++;
         if (rdata_valid !== 1'b0) $display("[TB] FAIL mfr_stray_rvalid: got %0b expected 0", rdata_valid);
         else n_pass++;
      end
      // Valid bits and memory were cleared: this must miss and return 00.
      tick(1'b0, 1'b1, 1'b1, 6'h15, 8'h00);
      for (int c = 0; c < 20 && m_busy(); c++) begin
         tick(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
         n_checks++;
         if (rdata_valid !== m_rvalid) $display("[TB] FAIL mfr_rvalid: got %0b expected %0b", rdata_valid, m_rvalid);
         else n_pass++;
      end
      n_checks++; if (miss_count !== 16'd1) $display("[TB] FAIL mfr_remiss: got %0d expected 1", miss_count); else n_pass++;
      n_checks++; if (rdata !== 8'h00) $display("[TB] FAIL mfr_rdata: got %0h expected 00", rdata); else n_pass++;
   endtask

   task automatic test_processor();
      tick(1'b1, 1'b1, 1'b1, 6'h00, 8'h00);
      for (int c = 0; c < 200; c++) begin
         tick(1'b0, 1'b1, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 8'($urandom));
         n_checks++;
         if (rdata_valid !== m_rvalid) $display("[TB] FAIL proc_rvalid: got %0b expected %0b", rdata_valid, m_rvalid);
         else n_pass++;
         if (m_rvalid) begin
            n_checks++;
            if (rdata !== m_rdata) $display("[TB] FAIL proc_rdata: got %0h expected %0h", rdata, m_rdata);
            else n_pass++;
         end
         n_checks++;
         if (busy !== m_busy()) $display("[TB] FAIL proc_busy: got %0b expected %0b", busy, m_busy());
         else n_pass++;
         n_checks++;
         if (drop_count !== 16'(m_drop)) $display("[TB] FAIL proc_drop: got %0d expected %0d", drop_count, m_drop);
         else n_pass++;
      end
      for (int c = 0; c < 100 && m_busy(); c++) begin
         tick(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
         n_checks++;
         if (rdata_valid !== m_rvalid) $display("[TB] FAIL proc_drain_rvalid: got %0b expected %0b", rdata_valid, m_rvalid);
         else n_pass++;
         if (m_rvalid) begin
            n_checks++;
            if (rdata !== m_rdata) $display("[TB] FAIL proc_drain_rdata: got %0h expected %0h", rdata, m_rdata);
            else n_pass++;
         end
      end
      n_checks++; if (busy !== 1'b0) $display("[TB] FAIL proc_idle: busy got %0b expected 0", busy); else n_pass++;
      n_checks++; if (hit_count !== 16'(m_hit)) $display("[TB] FAIL proc_hit: got %0d expected %0d", hit_count, m_hit); else n_pass++;
      n_checks++; if (miss_count !== 16'(m_miss)) $display("[TB] FAIL proc_miss: got %0d expected %0d", miss_count, m_miss); else n_pass++;
      n_checks++;
      if (32'(hit_count) + 32'(miss_count) + 32'(drop_count) !== 32'd200)
         $display("[TB] FAIL proc_total: got %0d expected 200", 32'(hit_count) + 32'(miss_count) + 32'(drop_count));
      else n_pass++;
   endtask

   initial begin
      start   = 1'b1;
      req_en  = 1'b0;
      RWB     = 1'b1;
      Address = 6'h00;
      Data    = 8'h00;
      @(negedge clk);
      test_reset();
      test_cold_read();
      test_write_allocate();
      test_overflow();
      test_mid_fill_reset();
      test_processor();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit, %0d/%0d passed so far", n_pass, n_checks);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
